// File: rtl/mpeg_stream_feeder.sv
// Streams len bytes from a byte-addressed source memory into an MPEG decoder input, honouring prog-full backpressure.
// Optional stall counter on down_cnt is built only when MPEG_FEEDER_DOWNTIME_CNT_EN is defined.
module mpeg_stream_feeder #(
  parameter int unsigned ADDR_W = 23
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mpeg_prog_full,
  output logic [7:0]        mpeg_out,
  output logic              mpeg_out_en,
  output logic              stream_end,
  output logic              busy,
  output logic [31:0]       byte_cnt,
  output logic [31:0]       down_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued_q;
  logic             rd_pend_q;
  logic             start_ok;

  // State register
  always_ff @(posedge clk) begin
    if (!srst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and read strobe; read strobe is combinational so prog_full stops reads the same cycle
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    start_ok  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          start_ok = 1'b1;
          state_d  = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        mem_rd_en = !mpeg_prog_full && (issued_q < len_q) && !abort && srst;
        if (mem_rd_en && ((issued_q + CNT_W'(1)) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!rd_pend_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Read tracking, two-stage output pipeline and byte counter
  always_ff @(posedge clk) begin
    if (!srst) begin
      len_q       <= '0;
      issued_q    <= '0;
      mem_addr    <= '0;
      rd_pend_q   <= 1'b0;
      mpeg_out    <= '0;
      mpeg_out_en <= 1'b0;
      byte_cnt    <= '0;
      stream_end  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_pend_q   <= mem_rd_en;
      mpeg_out_en <= rd_pend_q && !abort;
      if (rd_pend_q) mpeg_out <= mem_rdata;
      if (rd_pend_q && !abort) byte_cnt <= byte_cnt + 32'd1;
      if (start_ok) begin
        len_q    <= len;
        issued_q <= '0;
        mem_addr <= '0;
        byte_cnt <= '0;
      end else if (mem_rd_en) begin
        issued_q <= issued_q + CNT_W'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      stream_end <= (state_d == DONE);
      busy       <= (state_d == RUN) || (state_d == DRAIN);
    end
  end

`ifdef MPEG_FEEDER_DOWNTIME_CNT_EN
  logic [31:0] down_q;

  // Saturating count of RUN cycles lost to downstream backpressure
  always_ff @(posedge clk) begin
    if (!srst) begin
      down_q <= '0;
    end else if (start_ok) begin
      down_q <= '0;
    end else if ((state_q == RUN) && mpeg_prog_full && !abort && (down_q != 32'hFFFF_FFFF)) begin
      down_q <= down_q + 32'd1;
    end
  end

  assign down_cnt = down_q;
`else
  assign down_cnt = '0;
`endif

endmodule

// File: tb/tb_mpeg_stream_feeder.sv
// Directed bench for mpeg_stream_feeder with a one-cycle-latency source memory holding mem[i]=i.
// Expects down_cnt to count stalls only when MPEG_FEEDER_DOWNTIME_CNT_EN is defined.
module tb_mpeg_stream_feeder;

  localparam int unsigned AW = 8;

`ifdef MPEG_FEEDER_DOWNTIME_CNT_EN
  localparam logic [31:0] DOWN_EXP = 32'd20;
`else
  localparam logic [31:0] DOWN_EXP = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic          mpeg_prog_full = 1'b0;
  logic [7:0]    mpeg_out;
  logic          mpeg_out_en;
  logic          stream_end;
  logic          busy;
  logic [31:0]   byte_cnt;
  logic [31:0]   down_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] outq[$];
  int outc[$];
  int rdc[$];

  mpeg_stream_feeder #(.ADDR_W(AW)) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort), .len(len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mpeg_prog_full(mpeg_prog_full), .mpeg_out(mpeg_out), .mpeg_out_en(mpeg_out_en),
    .stream_end(stream_end), .busy(busy), .byte_cnt(byte_cnt), .down_cnt(down_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory: data for a read appears the cycle after the strobe
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 8'(mem_addr);

  // Record emitted bytes and reads with their cycle numbers
  always @(negedge clk) begin
    if (mpeg_out_en === 1'b1) begin
      outq.push_back(mpeg_out);
      outc.push_back(cyc);
    end
    if (mem_rd_en === 1'b1) rdc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int l);
    len = (AW + 1)'(l);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (stream_end !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    checks++; if (stream_end !== 1'b1) begin errors++; $display("FAIL %s_wait: stream_end=%b after %0d cycles, required 1", name, stream_end, n); end
  endtask

  task automatic test_reset;
    srst = 1'b0;
    tick(3);
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", mem_rd_en); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h required 0", mem_addr); end
    checks++; if (mpeg_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %0h required 0", mpeg_out); end
    checks++; if (mpeg_out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en: got %b required 0", mpeg_out_en); end
    checks++; if (stream_end !== 1'b0) begin errors++; $display("FAIL reset_stream_end: got %b required 0", stream_end); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (byte_cnt !== 32'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d required 0", byte_cnt); end
    checks++; if (down_cnt !== 32'd0) begin errors++; $display("FAIL reset_down_cnt: got %0d required 0", down_cnt); end
    srst = 1'b1;
    tick(1);
  endtask

  task automatic test_basic;
    int base = outq.size();
    int rb = rdc.size();
    int c0;
    pulse_start(16);
    c0 = cyc;
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL basic_first_rd: got %b required 1", mem_rd_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL basic_addr0: got %0h required 0", mem_addr); end
    wait_done("basic", 60);
    checks++; if (cyc != c0 + 18) begin errors++; $display("FAIL basic_end_cycle: got %0d required %0d", cyc - c0, 18); end
    checks++; if (outq.size() - base != 16) begin errors++; $display("FAIL basic_count: got %0d required 16", outq.size() - base); end
    checks++; if (rdc.size() - rb != 16) begin errors++; $display("FAIL basic_reads: got %0d required 16", rdc.size() - rb); end
    if (outq.size() - base >= 16) begin
      checks++; if (outc[base] != c0 + 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", outc[base] - c0); end
      checks++; if (outc[base+15] != c0 + 17) begin errors++; $display("FAIL basic_burst: got %0d required 17", outc[base+15] - c0); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (outq[base+i] !== 8'(i)) begin errors++; $display("FAIL basic_byte%0d: got %0h required %0h", i, outq[base+i], 8'(i)); end
      end
    end
    checks++; if (byte_cnt !== 32'd16) begin errors++; $display("FAIL basic_byte_cnt: got %0d required 16", byte_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b required 0", busy); end
  endtask

  task automatic test_backpressure;
    int base = outq.size();
    int rb = rdc.size();
    int c0;
    int stall_rd = 0;
    int stall_out = 0;
    pulse_start(100);
    c0 = cyc;
    for (int k = 0; k < 30; k++) begin
      mpeg_prog_full = (k >= 10);
      tick(1);
    end
    mpeg_prog_full = 1'b0;
    wait_done("bp", 300);
    for (int i = rb; i < rdc.size(); i++) if (rdc[i] >= c0 + 10 && rdc[i] <= c0 + 29) stall_rd++;
    for (int i = base; i < outq.size(); i++) if (outc[i] >= c0 + 10 && outc[i] <= c0 + 29) stall_out++;
    checks++; if (stall_rd != 0) begin errors++; $display("FAIL bp_stall_reads: got %0d required 0", stall_rd); end
    checks++; if (stall_out != 2) begin errors++; $display("FAIL bp_inflight: got %0d required 2", stall_out); end
    checks++; if (outq.size() - base != 100) begin errors++; $display("FAIL bp_count: got %0d required 100", outq.size() - base); end
    if (outq.size() - base >= 100) begin
      for (int i = 0; i < 100; i++) begin
        checks++; if (outq[base+i] !== 8'(i)) begin errors++; $display("FAIL bp_byte%0d: got %0h required %0h", i, outq[base+i], 8'(i)); end
      end
    end
    checks++; if (byte_cnt !== 32'd100) begin errors++; $display("FAIL bp_byte_cnt: got %0d required 100", byte_cnt); end
    checks++; if (down_cnt !== DOWN_EXP) begin errors++; $display("FAIL bp_down_cnt: got %0d required %0d", down_cnt, DOWN_EXP); end
    mpeg_prog_full = 1'b1;
    tick(3);
    mpeg_prog_full = 1'b0;
    checks++; if (down_cnt !== DOWN_EXP) begin errors++; $display("FAIL bp_down_cnt_done: got %0d required %0d", down_cnt, DOWN_EXP); end
  endtask

  task automatic test_len_zero;
    int base;
    int rb;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++; if (stream_end !== 1'b0) begin errors++; $display("FAIL zero_abort_clear: got %b required 0", stream_end); end
    base = outq.size();
    rb = rdc.size();
    pulse_start(0);
    checks++; if (stream_end !== 1'b1) begin errors++; $display("FAIL zero_stream_end: got %b required 1", stream_end); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
    tick(4);
    checks++; if (rdc.size() != rb) begin errors++; $display("FAIL zero_reads: got %0d required 0", rdc.size() - rb); end
    checks++; if (outq.size() != base) begin errors++; $display("FAIL zero_outs: got %0d required 0", outq.size() - base); end
    checks++; if (byte_cnt !== 32'd0) begin errors++; $display("FAIL zero_byte_cnt: got %0d required 0", byte_cnt); end
    checks++; if (stream_end !== 1'b1) begin errors++; $display("FAIL zero_hold: got %b required 1", stream_end); end
  endtask

  task automatic test_abort;
    int base = outq.size();
    int n = 0;
    pulse_start(50);
    while (byte_cnt !== 32'd20 && n < 200) begin
      tick(1);
      n++;
    end
    checks++; if (byte_cnt !== 32'd20) begin errors++; $display("FAIL abort_reach20: got %0d required 20", byte_cnt); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++; if (mpeg_out_en !== 1'b0) begin errors++; $display("FAIL abort_out_en: got %b required 0", mpeg_out_en); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en: got %b required 0", mem_rd_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    checks++; if (stream_end !== 1'b0) begin errors++; $display("FAIL abort_stream_end: got %b required 0", stream_end); end
    tick(5);
    checks++; if (outq.size() - base != 20) begin errors++; $display("FAIL abort_count: got %0d required 20", outq.size() - base); end
    checks++; if (byte_cnt !== 32'd20) begin errors++; $display("FAIL abort_byte_cnt: got %0d required 20", byte_cnt); end
    base = outq.size();
    pulse_start(5);
    wait_done("restart", 40);
    checks++; if (outq.size() - base != 5) begin errors++; $display("FAIL restart_count: got %0d required 5", outq.size() - base); end
    if (outq.size() - base >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (outq[base+i] !== 8'(i)) begin errors++; $display("FAIL restart_byte%0d: got %0h required %0h", i, outq[base+i], 8'(i)); end
      end
    end
    checks++; if (byte_cnt !== 32'd5) begin errors++; $display("FAIL restart_byte_cnt: got %0d required 5", byte_cnt); end
  endtask

  task automatic test_reset_mid;
    int sz;
    int rs;
    pulse_start(30);
    tick(3);
    srst = 1'b0;
    tick(1);
    srst = 1'b1;
    checks++; if (mpeg_out_en !== 1'b0) begin errors++; $display("FAIL rmid_out_en: got %b required 0", mpeg_out_en); end
    checks++; if (mpeg_out !== 8'h00) begin errors++; $display("FAIL rmid_out: got %0h required 0", mpeg_out); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rmid_addr: got %0h required 0", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
    checks++; if (byte_cnt !== 32'd0) begin errors++; $display("FAIL rmid_byte_cnt: got %0d required 0", byte_cnt); end
    checks++; if (stream_end !== 1'b0) begin errors++; $display("FAIL rmid_stream_end: got %b required 0", stream_end); end
    sz = outq.size();
    rs = rdc.size();
    tick(6);
    checks++; if (outq.size() != sz) begin errors++; $display("FAIL rmid_leak: got %0d bytes required 0", outq.size() - sz); end
    checks++; if (rdc.size() != rs) begin errors++; $display("FAIL rmid_reads: got %0d required 0", rdc.size() - rs); end
  endtask

  task automatic test_start_ignored;
    int base = outq.size();
    pulse_start(8);
    tick(2);
    len = (AW + 1)'(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("ign", 40);
    checks++; if (outq.size() - base != 8) begin errors++; $display("FAIL ign_count: got %0d required 8", outq.size() - base); end
    if (outq.size() - base >= 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (outq[base+i] !== 8'(i)) begin errors++; $display("FAIL ign_byte%0d: got %0h required %0h", i, outq[base+i], 8'(i)); end
      end
    end
    checks++; if (byte_cnt !== 32'd8) begin errors++; $display("FAIL ign_byte_cnt: got %0d required 8", byte_cnt); end
  endtask

  task automatic test_max_len;
    int base = outq.size();
    int rb = rdc.size();
    int bad = 0;
    pulse_start(256);
    wait_done("max", 400);
    checks++; if (rdc.size() - rb != 256) begin errors++; $display("FAIL max_reads: got %0d required 256", rdc.size() - rb); end
    checks++; if (outq.size() - base != 256) begin errors++; $display("FAIL max_count: got %0d required 256", outq.size() - base); end
    if (outq.size() - base >= 256) begin
      for (int i = 0; i < 256; i++) if (outq[base+i] !== 8'(i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL max_order: got %0d misplaced bytes required 0", bad); end
    end
    checks++; if (byte_cnt !== 32'd256) begin errors++; $display("FAIL max_byte_cnt: got %0d required 256", byte_cnt); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL max_addr_wrap: got %0h required 0", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
